// File: rtl/idma_desc64_pkg.sv
// ============================================================================
// Module   : idma_desc64_pkg
// Brief    : Shared types and constants for the desc64 completion write-back.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package idma_desc64_pkg;

    localparam int unsigned ADDR_WIDTH = 64;

    typedef logic [ADDR_WIDTH-1:0] addr_t;

    typedef struct packed {
        addr_t addr;
        logic  irq;
    } pending_entry_t;

    localparam logic [63:0] C_WB_COMPLETE_MARK = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef logic [1:0] wb_state_t;
    localparam wb_state_t WB_IDLE = 2'd0;
    localparam wb_state_t WB_REQ  = 2'd1;
    localparam wb_state_t WB_RSP  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/idma_desc64_pending_fifo.sv
// ============================================================================
// Module   : idma_desc64_pending_fifo
// Brief    : Synchronous FIFO of in-flight descriptor entries (no fall-through).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module idma_desc64_pending_fifo
    import idma_desc64_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  pending_entry_t             push_data_i,
    input  logic                       pop_i,
    output pending_entry_t             pop_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     usage_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    pending_entry_t   r_mem [DEPTH];
    logic [PTR_W:0]   r_wptr;
    logic [PTR_W:0]   r_rptr;
    logic [PTR_W:0]   w_usage;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer bit distinguishes full from empty
    assign w_usage   = r_wptr - r_rptr;
    assign full_o    = (w_usage == (PTR_W+1)'(DEPTH));
    assign empty_o   = (w_usage == '0);
    assign usage_o   = w_usage;
    assign w_do_push = push_i && !full_o;
    assign w_do_pop  = pop_i && !empty_o;
    assign pop_data_o = r_mem[r_rptr[PTR_W-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_push) r_mem[r_wptr[PTR_W-1:0]] <= push_data_i;
    end

endmodule

`default_nettype wire

// File: rtl/idma_desc64_completion_writeback.sv
// ============================================================================
// Module   : idma_desc64_completion_writeback
// Brief    : Pops one descriptor per completion and writes the all-ones marker
//            to its flags word; optional error capture via IDMA_DESC64_WB_ERROR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module idma_desc64_completion_writeback
    import idma_desc64_pkg::*;
#(
    parameter int unsigned AddrWidth    = 64,
    parameter int unsigned PendingDepth = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          desc_valid_i,
    output logic                          desc_ready_o,
    input  logic [AddrWidth-1:0]          desc_addr_i,
    input  logic                          desc_irq_i,
    input  logic                          done_available_i,
    output logic                          done_consume_o,
    output logic                          wb_req_o,
    output logic [AddrWidth-1:0]          wb_addr_o,
    output logic [63:0]                   wb_data_o,
    input  logic                          wb_gnt_i,
    input  logic                          wb_rsp_valid_i,
    input  logic                          wb_rsp_error_i,
`ifdef IDMA_DESC64_WB_ERROR_EN
    output logic                          wb_error_o,
    output logic [AddrWidth-1:0]          wb_error_addr_o,
`endif
    output logic                          irq_o,
    output logic [$clog2(PendingDepth):0] pending_count_o,
    output logic                          idle_o
);

    wb_state_t       r_state;
    addr_t           r_addr;
    logic            r_irq;
    logic            r_irq_pulse;

    pending_entry_t  w_push_entry;
    pending_entry_t  w_head;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_start;
    logic            w_rsp_done;

    assign w_push_entry.addr = addr_t'(desc_addr_i);
    assign w_push_entry.irq  = desc_irq_i;
    assign desc_ready_o      = !w_full;
    assign w_push            = desc_valid_i && !w_full;

    // A completion is only consumed when there is a descriptor to retire
    assign w_start    = (r_state == WB_IDLE) && !w_empty && done_available_i;
    assign w_rsp_done = (r_state == WB_RSP) && wb_rsp_valid_i;

    idma_desc64_pending_fifo #(
        .DEPTH       (PendingDepth)
    ) u_pending_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (w_push),
        .push_data_i (w_push_entry),
        .pop_i       (w_start),
        .pop_data_o  (w_head),
        .full_o      (w_full),
        .empty_o     (w_empty),
        .usage_o     (pending_count_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= WB_IDLE;
            r_addr      <= '0;
            r_irq       <= 1'b0;
            r_irq_pulse <= 1'b0;
        end else begin
            r_irq_pulse <= 1'b0;
            case (r_state)
                WB_IDLE: begin
                    if (w_start) begin
                        r_addr  <= w_head.addr;
                        r_irq   <= w_head.irq;
                        r_state <= WB_REQ;
                    end
                end
                WB_REQ: begin
                    if (wb_gnt_i) r_state <= WB_RSP;
                end
                WB_RSP: begin
                    if (w_rsp_done) begin
                        r_irq_pulse <= r_irq;
                        r_state     <= WB_IDLE;
                    end
                end
                default: r_state <= WB_IDLE;
            endcase
        end
    end

`ifdef IDMA_DESC64_WB_ERROR_EN
    logic  r_wb_error;
    addr_t r_wb_error_addr;

    // Only the first failing address is kept; the flag stays sticky
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wb_error      <= 1'b0;
            r_wb_error_addr <= '0;
        end else if (w_rsp_done && wb_rsp_error_i) begin
            r_wb_error <= 1'b1;
            if (!r_wb_error) r_wb_error_addr <= r_addr;
        end
    end

    assign wb_error_o      = r_wb_error;
    assign wb_error_addr_o = r_wb_error_addr[AddrWidth-1:0];
`else
    logic w_unused_rsp_error;
    assign w_unused_rsp_error = wb_rsp_error_i;
`endif

    assign done_consume_o = w_start;
    assign wb_req_o       = (r_state == WB_REQ);
    assign wb_addr_o      = r_addr[AddrWidth-1:0];
    assign wb_data_o      = C_WB_COMPLETE_MARK;
    assign irq_o          = r_irq_pulse;
    assign idle_o         = (r_state == WB_IDLE) && w_empty;

endmodule

`default_nettype wire

// File: tb/tb_idma_desc64_completion_writeback.sv
// ============================================================================
// Module   : tb_idma_desc64_completion_writeback
// Brief    : Directed self-checking bench for the completion write-back block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_idma_desc64_completion_writeback;

    logic        clk;
    logic        rst_ni;
    logic        desc_valid;
    logic        desc_ready;
    logic [63:0] desc_addr;
    logic        desc_irq;
    logic        done_available;
    logic        done_consume;
    logic        wb_req;
    logic [63:0] wb_addr;
    logic [63:0] wb_data;
    logic        wb_gnt;
    logic        wb_rsp_valid;
    logic        wb_rsp_error;
    logic        irq;
    logic [2:0]  pending_count;
    logic        idle;
`ifdef IDMA_DESC64_WB_ERROR_EN
    logic        wb_error;
    logic [63:0] wb_error_addr;
`endif

    int errors = 0;
    int checks = 0;

    idma_desc64_completion_writeback #(
        .AddrWidth        (64),
        .PendingDepth     (4)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .desc_valid_i     (desc_valid),
        .desc_ready_o     (desc_ready),
        .desc_addr_i      (desc_addr),
        .desc_irq_i       (desc_irq),
        .done_available_i (done_available),
        .done_consume_o   (done_consume),
        .wb_req_o         (wb_req),
        .wb_addr_o        (wb_addr),
        .wb_data_o        (wb_data),
        .wb_gnt_i         (wb_gnt),
        .wb_rsp_valid_i   (wb_rsp_valid),
        .wb_rsp_error_i   (wb_rsp_error),
`ifdef IDMA_DESC64_WB_ERROR_EN
        .wb_error_o       (wb_error),
        .wb_error_addr_o  (wb_error_addr),
`endif
        .irq_o            (irq),
        .pending_count_o  (pending_count),
        .idle_o           (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the edge; checks follow 1 unit later
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [63:0] a, input logic i);
        desc_valid = 1'b1;
        desc_addr  = a;
        desc_irq   = i;
        tick();
        desc_valid = 1'b0;
        #1;
    endtask

    initial begin
        rst_ni = 1'b0; desc_valid = 1'b0; desc_addr = '0; desc_irq = 1'b0;
        done_available = 1'b0; wb_gnt = 1'b0; wb_rsp_valid = 1'b0; wb_rsp_error = 1'b0;
        tick(); tick(); #1;
        chk("rst_ready", 64'(desc_ready), 64'd1);
        chk("rst_idle", 64'(idle), 64'd1);
        chk("rst_count", 64'(pending_count), 64'd0);
        chk("rst_req", 64'(wb_req), 64'd0);
        chk("rst_irq", 64'(irq), 64'd0);
        chk("rst_consume", 64'(done_consume), 64'd0);
        rst_ni = 1'b1;
        tick();

        // Basic completion with irq
        push(64'h1000, 1'b1);
        chk("t1_count", 64'(pending_count), 64'd1);
        chk("t1_notidle", 64'(idle), 64'd0);
        done_available = 1'b1; #1;
        chk("t1_consume", 64'(done_consume), 64'd1);
        tick(); done_available = 1'b0; #1;
        chk("t1_consume_once", 64'(done_consume), 64'd0);
        chk("t1_req", 64'(wb_req), 64'd1);
        chk("t1_addr", wb_addr, 64'h1000);
        chk("t1_data", wb_data, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t1_count0", 64'(pending_count), 64'd0);
        wb_gnt = 1'b1; tick(); wb_gnt = 1'b0; #1;
        chk("t1_req_drop", 64'(wb_req), 64'd0);
        tick(); #1;
        chk("t1_irq_wait", 64'(irq), 64'd0);
        wb_rsp_valid = 1'b1; tick(); wb_rsp_valid = 1'b0; #1;
        chk("t1_irq", 64'(irq), 64'd1);
        chk("t1_idle", 64'(idle), 64'd1);
        tick(); #1;
        chk("t1_irq_once", 64'(irq), 64'd0);

        // Fill queue, stall 5th push, drain in order
        for (int k = 0; k < 4; k++) push(64'h100 * (k + 1), 1'b0);
        chk("t2_full_ready", 64'(desc_ready), 64'd0);
        chk("t2_count4", 64'(pending_count), 64'd4);
        push(64'h500, 1'b0);
        chk("t2_stall_count", 64'(pending_count), 64'd4);
        done_available = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t2_consume", 64'(done_consume), 64'd1);
            tick(); #1;
            chk("t2_consume_1cyc", 64'(done_consume), 64'd0);
            chk("t2_req", 64'(wb_req), 64'd1);
            chk("t2_order", wb_addr, 64'h100 * (k + 1));
            wb_gnt = 1'b1; tick(); wb_gnt = 1'b0;
            wb_rsp_valid = 1'b1; tick(); wb_rsp_valid = 1'b0;
        end
        done_available = 1'b0; #1;
        chk("t2_idle", 64'(idle), 64'd1);
        chk("t2_no_irq", 64'(irq), 64'd0);

        // Grant held off for 10 cycles; second completion must wait
        push(64'h5000, 1'b0);
        push(64'h6000, 1'b0);
        done_available = 1'b1;
        tick(); #1;
        for (int k = 0; k < 10; k++) begin
            chk("t3_req_hold", 64'(wb_req), 64'd1);
            chk("t3_addr_hold", wb_addr, 64'h5000);
            chk("t3_no_consume", 64'(done_consume), 64'd0);
            tick(); #1;
        end
        wb_gnt = 1'b1; tick(); wb_gnt = 1'b0;
        wb_rsp_valid = 1'b1; tick(); wb_rsp_valid = 1'b0; #1;
        chk("t3_next_consume", 64'(done_consume), 64'd1);
        tick(); done_available = 1'b0; #1;
        chk("t3_next_addr", wb_addr, 64'h6000);
        wb_gnt = 1'b1; tick(); wb_gnt = 1'b0;
        wb_rsp_valid = 1'b1; tick(); wb_rsp_valid = 1'b0; #1;
        chk("t3_irq0", 64'(irq), 64'd0);
        chk("t3_idle", 64'(idle), 64'd1);

        // Completion signalled with empty queue
        done_available = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t4_no_consume", 64'(done_consume), 64'd0);
            chk("t4_no_req", 64'(wb_req), 64'd0);
            tick();
        end
        push(64'h2000, 1'b1);
        chk("t4_consume", 64'(done_consume), 64'd1);
        tick(); done_available = 1'b0; #1;
        chk("t4_req", 64'(wb_req), 64'd1);
        chk("t4_addr", wb_addr, 64'h2000);
        wb_gnt = 1'b1; wb_rsp_valid = 1'b1;
        tick(); wb_gnt = 1'b0; wb_rsp_valid = 1'b0; #1;
        chk("t4_samecyc_rsp_ignored", 64'(idle), 64'd0);
        chk("t4_samecyc_irq", 64'(irq), 64'd0);
        wb_rsp_valid = 1'b1; tick(); wb_rsp_valid = 1'b0; #1;
        chk("t4_irq", 64'(irq), 64'd1);
        chk("t4_idle", 64'(idle), 64'd1);
        tick();

`ifdef IDMA_DESC64_WB_ERROR_EN
        push(64'h3000, 1'b1);
        push(64'h4000, 1'b0);
        done_available = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            wb_gnt = 1'b1; tick(); wb_gnt = 1'b0;
            wb_rsp_valid = 1'b1; wb_rsp_error = 1'b1;
            tick(); wb_rsp_valid = 1'b0; wb_rsp_error = 1'b0; #1;
            if (k == 0) begin
                chk("t5_err_irq", 64'(irq), 64'd1);
                chk("t5_err", 64'(wb_error), 64'd1);
                chk("t5_err_addr", wb_error_addr, 64'h3000);
            end
        end
        done_available = 1'b0;
        chk("t5_err_sticky", 64'(wb_error), 64'd1);
        chk("t5_err_addr_kept", wb_error_addr, 64'h3000);
        tick();
`endif

        // Asynchronous reset while waiting for a response
        push(64'h7000, 1'b1);
        push(64'h8000, 1'b1);
        push(64'h9000, 1'b1);
        done_available = 1'b1;
        tick(); done_available = 1'b0;
        wb_gnt = 1'b1; tick(); wb_gnt = 1'b0; #1;
        chk("t6_pre_count", 64'(pending_count), 64'd2);
        chk("t6_pre_idle", 64'(idle), 64'd0);
        rst_ni = 1'b0; #1;
        chk("t6_idle", 64'(idle), 64'd1);
        chk("t6_count", 64'(pending_count), 64'd0);
        chk("t6_req", 64'(wb_req), 64'd0);
        chk("t6_irq", 64'(irq), 64'd0);
        chk("t6_ready", 64'(desc_ready), 64'd1);
`ifdef IDMA_DESC64_WB_ERROR_EN
        chk("t6_err_clr", 64'(wb_error), 64'd0);
`endif
        tick(); rst_ni = 1'b1;
        wb_rsp_valid = 1'b1; tick(); wb_rsp_valid = 1'b0; #1;
        chk("t6_post_irq", 64'(irq), 64'd0);
        chk("t6_post_idle", 64'(idle), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
